// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM encoding, shift-register width,
// data-length and parity-sense constants, and the frame-length helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

    localparam int SR_W       = 10;
    localparam int DATA_LEN_7 = 7;
    localparam int DATA_LEN_8 = 8;

    localparam logic ODD  = 1'b1;
    localparam logic EVEN = 1'b0;

    // Bits sampled after the start bit: data + optional parity + stop
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'(eight ? DATA_LEN_8 : DATA_LEN_7) + {3'b000, pen} + 4'd1;
    endfunction

endpackage

// File: rtl/uart_rx_engine_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; flops reset to 1
// so the idle-high line never looks like a start bit coming out of reset.
module rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset)
            ff <= '1;
        else
            ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start detect, bit-time counter control, 7/8-bit data
// with optional parity and stop check. Optional overrun flag via RX_OVERRUN_EN.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic       BTU,
    input  logic       rx_clr,
    output logic       start,
    output logic       doIt,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    rx_state_t       state;
    logic            rx_s;
    logic [3:0]      bit_cnt;
    logic [SR_W-1:0] shreg;
    logic [SR_W-1:0] new_shreg;
    logic [SR_W-1:0] frame;
    logic            eight_q;
    logic            pen_q;
    logic            ohel_q;
    logic [3:0]      n_len;
    logic [7:0]      data_bits;
    logic            par_bit;
    logic            stop_bit;
    logic            par_err;
    logic            last_bit;

    rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // The frame is right-aligned from the post-shift value so completion
    // can happen in the same edge as the final sample.
    always_comb begin
        n_len     = frame_len(eight_q, pen_q);
        new_shreg = {rx_s, shreg[SR_W-1:1]};
        frame     = new_shreg >> (4'(SR_W) - n_len);
        data_bits = eight_q ? frame[7:0] : {1'b0, frame[6:0]};
        par_bit   = frame[n_len - 4'd2];
        stop_bit  = frame[n_len - 4'd1];
        par_err   = pen_q & ((^data_bits ^ par_bit) != ohel_q);
        last_bit  = (state == DATA) && BTU && (bit_cnt == n_len - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            start   <= 1'b0;
            doIt    <= 1'b0;
            bit_cnt <= 4'd0;
            shreg   <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= EVEN;
            rx_data <= 8'h00;
            rx_rdy  <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (rx_clr) begin
                rx_rdy <= 1'b0;
                perr   <= 1'b0;
                ferr   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    start <= 1'b0;
                    doIt  <= 1'b0;
                    if (!rx_s) begin
                        state   <= START;
                        start   <= 1'b1;
                        doIt    <= 1'b1;
                        eight_q <= eight;
                        pen_q   <= pen;
                        ohel_q  <= ohel;
                    end
                end
                START: begin
                    if (BTU) begin
                        start <= 1'b0;
                        if (rx_s) begin
                            state <= IDLE;
                            doIt  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= 4'd0;
                        end
                    end
                end
                DATA: begin
                    if (BTU) begin
                        shreg   <= new_shreg;
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    // Completion overrides a coincident rx_clr
                    if (last_bit) begin
                        state   <= IDLE;
                        doIt    <= 1'b0;
                        rx_data <= data_bits;
                        perr    <= par_err;
                        ferr    <= ~stop_bit;
                        rx_rdy  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    start <= 1'b0;
                    doIt  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (rx_clr)
            ovf <= 1'b0;
        else if (last_bit && rx_rdy)
            ovf <= 1'b1;
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine paired with a behavioural bit-time counter
// (k = 109, k_div2 = 55, 10 ns clock); table vectors plus corner sequences.
module tb_uart_rx_engine;

    localparam int K      = 109;
    localparam int K_DIV2 = 55;

`ifdef RX_OVERRUN_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       btu;
    logic       rx_clr;
    logic       start;
    logic       doIt;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       perr;
    logic       ferr;
    logic       ovf;

    logic [7:0] bcnt;

    int checks = 0;
    int errors = 0;

    int  btu_count = 0;
    int  rdy_btus = 0;
    logic rdy_after_btu = 1'b0;
    logic rdy_prev = 1'b0;
    logic btu_prev = 1'b0;
    int  frame_base = 0;

    typedef struct {
        logic       eight;
        logic       pen;
        logic       ohel;
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    // Receive bit-time counter: held clear while doIt = 0
    assign btu = doIt && (bcnt == (start ? 8'(K_DIV2 - 1) : 8'(K - 1)));

    always @(posedge clk) begin
        if (reset || !doIt || btu)
            bcnt <= 8'd0;
        else
            bcnt <= bcnt + 8'd1;
    end

    uart_rx_engine #(.SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .BTU     (btu),
        .rx_clr  (rx_clr),
        .start   (start),
        .doIt    (doIt),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    // Records how many BTUs had occurred when rx_rdy rose, and whether a BTU came the cycle before
    always @(negedge clk) begin
        if (rx_rdy && !rdy_prev) begin
            rdy_btus      = btu_count;
            rdy_after_btu = btu_prev;
        end
        rdy_prev = rx_rdy;
        btu_prev = btu;
        if (btu)
            btu_count = btu_count + 1;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h expected 0x%02h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset  = 1'b1;
        rx     = 1'b1;
        rx_clr = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    task automatic sendBit(input logic b);
        rx = b;
        tick(K);
    endtask

    task automatic applyStimulus(input logic e, input logic p, input logic o,
                                 input logic [7:0] d, input logic par, input logic stp);
        eight = e;
        pen   = p;
        ohel  = o;
        @(negedge clk);
        frame_base = btu_count;
        sendBit(1'b0);
        for (int i = 0; i < (e ? 8 : 7); i++)
            sendBit(d[i]);
        if (p)
            sendBit(par);
        sendBit(stp);
        rx = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        eight  = 1'b1;
        pen    = 1'b0;
        ohel   = 1'b0;
        rx_clr = 1'b0;

        //          eight pen  ohel data   par  stp  exp    perr ferr
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, 8'h37, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};

        doReset();
        checkOutput("reset_flags", {2'b00, start, doIt, rx_rdy, perr, ferr, ovf}, 8'h00);
        checkOutput("reset_data", rx_data, 8'h00);

        for (int v = 0; v < 7; v++) begin
            doReset();
            applyStimulus(vecs[v].eight, vecs[v].pen, vecs[v].ohel,
                          vecs[v].data, vecs[v].par, vecs[v].stp);
            tick(5);
            checkOutput($sformatf("v%0d_rdy", v), {7'd0, rx_rdy}, 8'h01);
            checkOutput($sformatf("v%0d_data", v), rx_data, vecs[v].exp_data);
            checkOutput($sformatf("v%0d_perr", v), {7'd0, perr}, {7'd0, vecs[v].exp_perr});
            checkOutput($sformatf("v%0d_ferr", v), {7'd0, ferr}, {7'd0, vecs[v].exp_ferr});
            checkOutput($sformatf("v%0d_ovf", v), {7'd0, ovf}, 8'h00);
            checkOutput($sformatf("v%0d_rdy_timing", v),
                        {rdy_after_btu, 7'(rdy_btus - frame_base)},
                        {1'b1, 7'((vecs[v].eight ? 8 : 7) + (vecs[v].pen ? 1 : 0) + 2)});
            if (vecs[v].stp)
                checkOutput($sformatf("v%0d_rearm", v), {6'd0, start, doIt}, 8'h00);
        end

        // False start: line low for 30 cycles only
        doReset();
        @(negedge clk);
        rx = 1'b0;
        tick(5);
        checkOutput("false_start_armed", {6'd0, start, doIt}, 8'h03);
        tick(25);
        rx = 1'b1;
        tick(70);
        checkOutput("false_start_abort", {5'd0, start, doIt, rx_rdy}, 8'h00);
        rx_clr = 1'b1;
        tick(1);
        rx_clr = 1'b0;
        tick(1);
        checkOutput("clr_when_idle", {2'b00, start, doIt, rx_rdy, perr, ferr, ovf}, 8'h00);

        // Two frames back to back without acknowledge, then acknowledge
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1);
        tick(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1);
        tick(5);
        checkOutput("ovr_data", rx_data, 8'h22);
        checkOutput("ovr_rdy", {7'd0, rx_rdy}, 8'h01);
        checkOutput("ovr_flag", {7'd0, ovf}, {7'd0, EXP_OVF});
        rx_clr = 1'b1;
        tick(1);
        rx_clr = 1'b0;
        tick(1);
        checkOutput("ovr_cleared", {4'd0, rx_rdy, perr, ferr, ovf}, 8'h00);
        checkOutput("ovr_data_kept", rx_data, 8'h22);

        // Reset after the fourth data bit, then a clean frame
        doReset();
        eight = 1'b1;
        pen   = 1'b0;
        @(negedge clk);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("midframe_running", {6'd0, start, doIt}, 8'h01);
        reset = 1'b1;
        rx    = 1'b1;
        tick(1);
        checkOutput("midframe_reset_flags", {2'b00, start, doIt, rx_rdy, perr, ferr, ovf}, 8'h00);
        checkOutput("midframe_reset_data", rx_data, 8'h00);
        reset = 1'b0;
        tick(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1);
        tick(5);
        checkOutput("after_reset_rdy", {7'd0, rx_rdy}, 8'h01);
        checkOutput("after_reset_data", rx_data, 8'h3C);
        checkOutput("after_reset_errs", {6'd0, perr, ferr}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
